// File: rtl/decoder_index_serializer.sv
// Serializes a multi-hot request vector into binary indices, lowest set bit first.
// Optional sticky zero-vector error flag: define DECODER_INDEX_SERIALIZER_ZERO_ERR_EN.
module decoder_index_serializer #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [N-1:0]   remain_s;
  logic           accept_s;
  logic           handshake_s;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
  logic           err_q, err_d;
`endif

  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] idx_to_bit(input logic [W-1:0] idx);
    logic [N-1:0] vec;
    for (int i = 0; i < N; i++) begin
      vec[i] = (idx == W'(i));
    end
    return vec;
  endfunction

  // True when more than one bit is set (clears the lowest bit, then tests the rest).
  function automatic logic multi_hot(input logic [N-1:0] vec);
    return |(vec & (vec - {{(N-1){1'b0}}, 1'b1}));
  endfunction

  assign accept_s    = in_valid & in_ready;
  assign handshake_s = out_valid_q & out_ready;
  assign remain_s    = pending_q & ~idx_to_bit(out_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (in != {N{1'b0}})) begin
          state_d = SERVE;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (handshake_s && (remain_s == {N{1'b0}})) begin
          state_d = IDLE;
        end else begin
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; everything is held unless a capture or handshake occurs.
  always_comb begin
    pending_d   = pending_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s && (in != {N{1'b0}})) begin
          pending_d   = in;
          out_d       = lowest_idx(in);
          out_valid_d = 1'b1;
          out_last_d  = ~multi_hot(in);
        end else if (accept_s) begin
          // Zero vector: consumed and dropped.
          pending_d = pending_q;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
          err_d     = 1'b1;
`endif
        end else begin
          pending_d = pending_q;
        end
      end
      SERVE: begin
        if (handshake_s && (remain_s != {N{1'b0}})) begin
          pending_d  = remain_s;
          out_d      = lowest_idx(remain_s);
          out_last_d = ~multi_hot(remain_s);
        end else if (handshake_s) begin
          pending_d   = {N{1'b0}};
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        pending_d   = {N{1'b0}};
        out_d       = {W{1'b0}};
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= {N{1'b0}};
      out_q       <= {W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  // Output decode.
  always_comb begin
    in_ready  = en & (state_q == IDLE);
    busy      = (state_q == SERVE);
    out       = out_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
    err       = err_q;
`endif
  end

endmodule

// File: tb/tb_decoder_index_serializer.sv
// Bench for decoder_index_serializer: directed plan steps then random traffic,
// compared against a queue-of-indices reference model.
module tb_decoder_index_serializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
  logic       err;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: the indices still owed to the consumer, in emission order.
  int q[$];
  logic exp_err = 1'b0;

  decoder_index_serializer #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
    check("out_last", {31'd0, out_last}, {31'd0, (q.size() == 1)});
    check("busy", {31'd0, busy}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      check("out", {30'd0, out}, q[0]);
    end
`ifdef DECODER_INDEX_SERIALIZER_ZERO_ERR_EN
    check("err", {31'd0, err}, {31'd0, exp_err});
`endif
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic cyc(input logic r, input logic e, input logic iv,
                     input logic [3:0] v, input logic ordy);
    rst = r; en = e; in_valid = iv; in_vec = v; out_ready = ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (e && q.size() == 0)});
    if (r) begin
      q.delete();
      exp_err = 1'b0;
    end else if (q.size() > 0 && ordy) begin
      void'(q.pop_front());
    end else if (e && q.size() == 0 && iv) begin
      if (v == 4'd0) exp_err = 1'b1;
      for (int i = 0; i < 4; i++) if (v[i]) q.push_back(i);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_vec = 4'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset / idle
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    check("rst_out", {30'd0, out}, 32'd0);
    // Single bit
    cyc(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1);
    check("single_out", {30'd0, out}, 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // Multi-bit drain
    cyc(1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("drain_last_idx", {30'd0, out}, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // Backpressure with a competing request
    cyc(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 4'b1000, 1'b0);
    check("bp_hold_out", {30'd0, out}, 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 4'b1000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // en low while serving
    cyc(1'b0, 1'b1, 1'b1, 4'b1001, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // Reset mid-serve
    cyc(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // Zero vector, then a normal vector
    cyc(1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 1) == 1),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 9) < 6));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
